// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// Data wins by default; a wait counter forces a fetch grant. Optional MEM_ARB_STATS_EN adds arb_conflicts.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]       arb_conflicts
`endif
);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } own_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
   end

   logic [3:0] wcnt;
   own_t       rd_own;
   logic       fetch_win;
   logic       data_win;

   // Stage 0: combinational arbitration and memory port mux
   always_comb begin
      fetch_win = i_req && (!d_req || (wcnt == WAIT_MAX));
      data_win  = d_req && !fetch_win;
      i_gnt     = fetch_win;
      d_gnt     = data_win;
      mem_en    = fetch_win || data_win;
      mem_we    = data_win && d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (fetch_win) begin
         mem_addr = i_addr;
      end else if (data_win) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Stage 1: starvation counter and read-owner tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt   <= '0;
         rd_own <= OWN_NONE;
      end else begin
         if (i_req && !fetch_win) begin
            wcnt <= (wcnt == WAIT_MAX) ? wcnt : wcnt + 4'd1;
         end else begin
            wcnt <= '0;
         end
         if (fetch_win) begin
            rd_own <= OWN_FETCH;
         end else if (data_win && !d_we) begin
            rd_own <= OWN_DATA;
         end else begin
            rd_own <= OWN_NONE;
         end
      end
   end

   // rst during the return cycle discards the in-flight read
   assign i_rvalid = (rd_own == OWN_FETCH) && !rst;
   assign d_rvalid = (rd_own == OWN_DATA) && !rst;
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         arb_conflicts <= '0;
      end else if (i_req && d_req && (arb_conflicts != 16'hFFFF)) begin
         arb_conflicts <= arb_conflicts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory, a reference arbiter model,
// and per-port queues of expected read data.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
   logic [DW-1:0] i_rdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   arb_conflicts;
`endif

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
      , .arb_conflicts(arb_conflicts)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int k);
      return 32'hC0DE_0000 ^ (32'(k) * 32'h0101_0007);
   endfunction

   // Behavioural single-port memory, one-cycle read latency
   logic [31:0] mem [0:255];
   logic        fill;
   always @(posedge clk) begin
      if (fill) begin
         for (int k = 0; k < 256; k++) mem[k] <= pat(k);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[9:2]];
      end
   end

   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] ref_mem [0:255];
   logic [31:0] iq [$];
   logic [31:0] dq [$];
   int          m_wcnt;
   int          m_own;     // 0 none, 1 fetch, 2 data
   int          m_conf;
   logic        last_f, last_d;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs at negedge, advance the model, return just after posedge
   task automatic tick();
      logic exp_f, exp_d, exp_iv, exp_dv;
      @(negedge clk);
      exp_f  = i_req && (!d_req || m_wcnt == MW);
      exp_d  = d_req && !exp_f;
      exp_iv = (m_own == 1) && !rst;
      exp_dv = (m_own == 2) && !rst;
      chk("i_gnt", 32'(i_gnt), 32'(exp_f));
      chk("d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("mem_en", 32'(mem_en), 32'(exp_f || exp_d));
      chk("mem_we", 32'(mem_we), 32'(exp_d && d_we));
      chk("mem_addr", mem_addr, exp_f ? i_addr : (exp_d ? d_addr : 32'h0));
      if (!exp_f) chk("mem_wdata", mem_wdata, exp_d ? d_wdata : 32'h0);
      chk("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
      chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
      if (exp_iv) begin
         if (iq.size() > 0) chk("i_rdata", i_rdata, iq.pop_front());
         else chk("iq_underflow", 32'(iq.size()), 32'd1);
      end
      if (exp_dv) begin
         if (dq.size() > 0) chk("d_rdata", d_rdata, dq.pop_front());
         else chk("dq_underflow", 32'(dq.size()), 32'd1);
      end
`ifdef MEM_ARB_STATS_EN
      chk("arb_conflicts", 32'(arb_conflicts), 32'(m_conf));
`endif
      last_f = exp_f;
      last_d = exp_d;
      if (rst) begin
         m_wcnt = 0;
         m_own  = 0;
         m_conf = 0;
         iq.delete();
         dq.delete();
      end else begin
         m_wcnt = (i_req && !exp_f) ? ((m_wcnt < MW) ? m_wcnt + 1 : MW) : 0;
         m_own  = exp_f ? 1 : ((exp_d && !d_we) ? 2 : 0);
         if (i_req && d_req && m_conf < 16'hFFFF) m_conf++;
         if (exp_f) iq.push_back(ref_mem[i_addr[9:2]]);
         if (exp_d && !d_we) dq.push_back(ref_mem[d_addr[9:2]]);
         if (exp_d && d_we) ref_mem[d_addr[9:2]] = d_wdata;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
      m_wcnt = 0; m_own = 0; m_conf = 0;
      idle();
      rst = 1'b1;
      fill = 1'b1;
      @(posedge clk);
      #1;
      tick();
      fill = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // Fetch-only stream
      for (int k = 0; k < 3; k++) begin
         i_req = 1'b1; i_addr = 32'(k * 4);
         tick();
         chk("fetch_only_gnt", 32'(last_f), 32'd1);
      end
      idle();
      tick();
      tick();

      // Store then load of the same word
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
      tick();
      d_we = 1'b0; d_wdata = 32'h0;
      tick();
      idle();
      tick();
      chk("store_load_word", ref_mem[4], 32'hDEAD_BEEF);

      // Sustained contention
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("cont_i_gnt", 32'(last_f), 32'((k == 3) || (k == 7)));
         chk("cont_d_gnt", 32'(last_d), 32'(!((k == 3) || (k == 7))));
      end
      idle();
      tick();

      // Simultaneous single load plus fetch
      i_req = 1'b1; i_addr = 32'h4;
      d_req = 1'b1; d_addr = 32'h10;
      tick();
      chk("simul_data_first", 32'(last_d), 32'd1);
      d_req = 1'b0;
      tick();
      chk("simul_fetch_next", 32'(last_f), 32'd1);
      idle();
      tick();
      tick();

      // Contention builds wcnt, then reset while a load is in flight
      i_req = 1'b1; i_addr = 32'h8;
      d_req = 1'b1; d_addr = 32'h44;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_data_wins", 32'(last_d), 32'd1);
      idle();
      tick();
      tick();

      // Fetch gives up mid-wait; counter must restart
      i_req = 1'b1; i_addr = 32'hC;
      d_req = 1'b1; d_addr = 32'h48;
      tick();
      tick();
      i_req = 1'b0;
      tick();
      i_req = 1'b1;
      tick();
      chk("abandon_data_wins", 32'(last_d), 32'd1);
      idle();
      tick();
      tick();

      // Random traffic honouring the hold-until-grant rule
      for (int k = 0; k < 60; k++) begin
         if (!i_req || last_f) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = 32'($urandom_range(0, 63)) << 2;
         end
         if (!d_req || last_d) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 32'($urandom_range(0, 63)) << 2;
            d_wdata = $urandom;
         end
         tick();
      end
      idle();
      tick();
      tick();
      chk("iq_drained", 32'(iq.size()), 32'd0);
      chk("dq_drained", 32'(dq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
